sound_phase_gen: RTL and testbench

SOUND_PHASE_GEN -- requirements
Module: sound_phase_gen

---
 rtl/sound_pkg.sv | 13 +
 rtl/sound_phase_gen.sv | 136 +++++++++++++
 tb/tb_sound_phase_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound phase generator: state encoding and default widths.
package sound_pkg;

  localparam int unsigned ACC_WIDTH_DEF = 16;
  localparam int unsigned DUR_WIDTH     = 16;
  localparam int unsigned ST_WIDTH      = 2;

  // Tone-player states
  localparam logic [ST_WIDTH-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_WIDTH-1:0] ST_PLAY  = 2'd1;
  localparam logic [ST_WIDTH-1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/sound_phase_gen.sv
// Phase-accumulator tone generator producing sine-table addresses; tones end on a phase wrap.
module sound_phase_gen
  import sound_pkg::*;
#(
  parameter int unsigned COUNT_SIZE = 8,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  sample_tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ACC_WIDTH-1:0]  freq_word,
  input  logic [DUR_WIDTH-1:0]  duration,
  output logic [COUNT_SIZE-1:0] ADDR,
  output logic                  addr_valid,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  done
);

  logic [ST_WIDTH-1:0]   state, state_nxt;
  logic [ACC_WIDTH-1:0]  acc, acc_nxt;
  logic [ACC_WIDTH-1:0]  inc, inc_nxt;
  logic [DUR_WIDTH-1:0]  remaining, rem_nxt;
  logic [COUNT_SIZE-1:0] addr_nxt;
  logic                  addr_valid_nxt;
  logic                  done_nxt;
  logic                  end_cond;
  logic [ACC_WIDTH:0]    sum;
  logic                  carry;

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    inc_nxt        = inc;
    rem_nxt        = remaining;
    addr_nxt       = ADDR;
    addr_valid_nxt = 1'b0;
    done_nxt       = 1'b0;
    end_cond       = 1'b0;
    sum            = {1'b0, acc} + {1'b0, inc};
    carry          = sum[ACC_WIDTH];

    case (state)
      ST_IDLE: begin
        addr_nxt = '0;
        // A coincident tick does not advance; the first advance happens in PLAY.
        if (start && (freq_word != '0)) begin
          inc_nxt   = freq_word;
          rem_nxt   = duration;
          acc_nxt   = '0;
          state_nxt = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (sample_tick) begin
          acc_nxt        = sum[ACC_WIDTH-1:0];
          addr_nxt       = sum[ACC_WIDTH-1 -: COUNT_SIZE];
          addr_valid_nxt = 1'b1;
          if (remaining != '0) begin
            rem_nxt = remaining - DUR_WIDTH'(1);
            if (remaining == DUR_WIDTH'(1)) end_cond = 1'b1;
          end
        end
        // Stop beats retrigger; a retrigger reloads the countdown and cancels its expiry.
        if (stop) begin
          end_cond = 1'b1;
        end else if (start) begin
          if (freq_word != '0) inc_nxt = freq_word;
          rem_nxt  = duration;
          end_cond = 1'b0;
        end
        if (end_cond) begin
          if (sample_tick && carry) begin
            acc_nxt   = '0;
            addr_nxt  = '0;
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (sample_tick) begin
          addr_valid_nxt = 1'b1;
          if (carry) begin
            acc_nxt   = '0;
            addr_nxt  = '0;
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            acc_nxt  = sum[ACC_WIDTH-1:0];
            addr_nxt = sum[ACC_WIDTH-1 -: COUNT_SIZE];
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        acc_nxt   = '0;
        addr_nxt  = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= ST_IDLE;
      acc          <= '0;
      inc          <= '0;
      remaining    <= '0;
      ADDR         <= '0;
      addr_valid   <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      inc          <= inc_nxt;
      remaining    <= rem_nxt;
      ADDR         <= addr_nxt;
      addr_valid   <= addr_valid_nxt;
      sample_valid <= addr_valid;
      busy         <= (state_nxt != ST_IDLE);
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sound_phase_gen.sv
// Directed bench for sound_phase_gen with hand-computed expected addresses.
module tb_sound_phase_gen;

  logic        clk;
  logic        resetN;
  logic        sample_tick;
  logic        start;
  logic        stop;
  logic [15:0] freq_word;
  logic [15:0] duration;
  logic [7:0]  ADDR;
  logic        addr_valid;
  logic        sample_valid;
  logic        busy;
  logic        done;

  int pass_cnt;
  int total_cnt;
  int n;

  sound_phase_gen #(.COUNT_SIZE(8), .ACC_WIDTH(16)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .sample_tick  (sample_tick),
    .start        (start),
    .stop         (stop),
    .freq_word    (freq_word),
    .duration     (duration),
    .ADDR         (ADDR),
    .addr_valid   (addr_valid),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply one clock cycle of pulse inputs, then sample 1ns after the edge
  task automatic cyc(input logic tk, input logic st, input logic sp);
    sample_tick = tk;
    start       = st;
    stop        = sp;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    resetN = 1'b0;
    sample_tick = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    freq_word = '0;
    duration = '0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    resetN = 1'b1;
    cyc(0, 0, 0);

    // Reset state
    check("rst_addr", 32'(ADDR), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_av", 32'(addr_valid), 0);
    check("rst_sv", 32'(sample_valid), 0);

    // Scenario 1: 0x0100 continuous, start coincident with a tick does not advance
    freq_word = 16'h0100; duration = 16'd0;
    cyc(1, 1, 0);
    check("s1_busy", 32'(busy), 1);
    check("s1_start_addr", 32'(ADDR), 0);
    check("s1_start_av", 32'(addr_valid), 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0);
      check("s1_addr", 32'(ADDR), 32'(i));
      check("s1_av", 32'(addr_valid), 1);
      check("s1_sv_early", 32'(sample_valid), 0);
      cyc(0, 0, 0);
      check("s1_av_off", 32'(addr_valid), 0);
      check("s1_sv", 32'(sample_valid), 1);
      check("s1_hold", 32'(ADDR), 32'(i));
    end
    cyc(0, 0, 1);
    check("s1_drain_busy", 32'(busy), 1);
    n = 0;
    while (!done && n < 300) begin
      cyc(1, 0, 0);
      n++;
    end
    check("s1_drain_ticks", 32'(n), 251);
    check("s1_end_addr", 32'(ADDR), 0);
    check("s1_end_busy", 32'(busy), 0);

    // Scenario 2: duration 4 ends on a carry tick, straight to IDLE
    freq_word = 16'h4000; duration = 16'd4;
    cyc(0, 1, 0);
    cyc(1, 0, 0); check("s2_a1", 32'(ADDR), 32'h40); check("s2_b1", 32'(busy), 1);
    cyc(1, 0, 0); check("s2_a2", 32'(ADDR), 32'h80); check("s2_b2", 32'(busy), 1);
    cyc(1, 0, 0); check("s2_a3", 32'(ADDR), 32'hC0); check("s2_b3", 32'(busy), 1);
    check("s2_d3", 32'(done), 0);
    cyc(1, 0, 0);
    check("s2_a4", 32'(ADDR), 32'h00);
    check("s2_b4", 32'(busy), 0);
    check("s2_done", 32'(done), 1);
    check("s2_av4", 32'(addr_valid), 1);
    cyc(0, 0, 0);
    check("s2_done_once", 32'(done), 0);

    // Scenario 3: stop after tick 2 drains to the next wrap
    freq_word = 16'h3000; duration = 16'd0;
    cyc(0, 1, 0);
    cyc(1, 0, 0); check("s3_a1", 32'(ADDR), 32'h30);
    cyc(1, 0, 0); check("s3_a2", 32'(ADDR), 32'h60);
    cyc(0, 0, 1); check("s3_stop_busy", 32'(busy), 1);
    cyc(1, 0, 0); check("s3_a3", 32'(ADDR), 32'h90);
    cyc(1, 0, 0); check("s3_a4", 32'(ADDR), 32'hC0);
    cyc(1, 0, 0); check("s3_a5", 32'(ADDR), 32'hF0);
    check("s3_busy5", 32'(busy), 1);
    cyc(1, 0, 0);
    check("s3_a6", 32'(ADDR), 32'h00);
    check("s3_done", 32'(done), 1);
    check("s3_busy6", 32'(busy), 0);

    // Scenario 4: retrigger keeps phase and reloads duration
    freq_word = 16'h2000; duration = 16'd0;
    cyc(0, 1, 0);
    cyc(1, 0, 0); check("s4_a1", 32'(ADDR), 32'h20);
    freq_word = 16'h0200; duration = 16'd3;
    cyc(0, 1, 0); check("s4_retrig_hold", 32'(ADDR), 32'h20);
    cyc(1, 0, 0); check("s4_a2", 32'(ADDR), 32'h22);
    cyc(1, 0, 0); check("s4_a3", 32'(ADDR), 32'h24);
    cyc(1, 0, 0); check("s4_a4", 32'(ADDR), 32'h26);
    n = 0;
    while (!done && n < 150) begin
      cyc(1, 0, 0);
      n++;
    end
    check("s4_drain_ticks", 32'(n), 109);
    check("s4_end_busy", 32'(busy), 0);

    // Scenario 5: start+stop together drains with the old increment
    freq_word = 16'h1000; duration = 16'd0;
    cyc(0, 1, 0);
    cyc(1, 0, 0); check("s5_a1", 32'(ADDR), 32'h10);
    freq_word = 16'h0800;
    cyc(0, 1, 1); check("s5_busy", 32'(busy), 1);
    cyc(1, 0, 0); check("s5_old_inc", 32'(ADDR), 32'h20);
    n = 0;
    while (!done && n < 20) begin
      cyc(1, 0, 0);
      n++;
    end
    check("s5_drain_ticks", 32'(n), 14);
    freq_word = 16'h0000;
    cyc(0, 1, 0);
    check("s5_zero_busy", 32'(busy), 0);
    check("s5_zero_done", 32'(done), 0);
    cyc(1, 0, 0);
    check("s5_idle_addr", 32'(ADDR), 0);
    check("s5_idle_av", 32'(addr_valid), 0);

    // Scenario 6: reset mid-PLAY aborts with no done
    freq_word = 16'h0100; duration = 16'd0;
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0); check("s6_a2", 32'(ADDR), 32'h02);
    resetN = 1'b0;
    cyc(1, 0, 0);
    resetN = 1'b1;
    check("s6_addr", 32'(ADDR), 0);
    check("s6_av", 32'(addr_valid), 0);
    check("s6_sv", 32'(sample_valid), 0);
    check("s6_busy", 32'(busy), 0);
    check("s6_done", 32'(done), 0);
    cyc(0, 0, 0);
    check("s6_done_after", 32'(done), 0);
    check("s6_busy_after", 32'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
